fp_divider: RTL and testbench

- Sequential IEEE-754 single-precision divider; Quotient = Number_1 / Number_2.
- Inverse operation to the pipeline's float multiplier, used by the inverse-square-root datapath for Newton-step normalisation and result checking.
- Iterative restoring mantissa division with fixed, operand-independent latency.
- ce/Ready/Valid handshake; one operation in flight.

---
 rtl/fp_div_pkg.sv | 24 ++
 rtl/fp_div_mant_core.sv | 51 +++++
 rtl/fp_divider.sv | 124 ++++++++++++
 tb/tb_fp_divider.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants for the float32 divider.
// FP_DIV_ROUND_NEAREST_EN adds a guard iteration for round-to-nearest-even.
package fp_div_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

`ifdef FP_DIV_ROUND_NEAREST_EN
    localparam int ITERS = MAN_W + 3;
`else
    localparam int ITERS = MAN_W + 2;
`endif

    localparam int CNT_W = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;

    localparam logic [30:0] FP_ZERO = 31'h0;
    localparam logic [30:0] FP_INF  = {8'hFF, 23'h0};

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring divider for 24-bit hidden-bit mantissas, one quotient bit per cycle.
// Iteration count follows FP_DIV_ROUND_NEAREST_EN via the package.
module fp_div_mant_core
    import fp_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAN_W:0]   dividend,
    input  logic [MAN_W:0]   divisor,
    output logic [ITERS-1:0] q,
    output logic             rem_nz,
    output logic             done
);

    logic [MAN_W+2:0] r;
    logic [MAN_W:0]   d;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             ge;
    logic [MAN_W+2:0] diff;

    assign ge     = r >= {2'b00, d};
    assign diff   = ge ? r - {2'b00, d} : r;
    assign done   = busy && (cnt == CNT_W'(ITERS - 1));
    assign rem_nz = |r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r    <= '0;
            d    <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            r    <= {2'b00, dividend};
            d    <= divisor;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            q   <= {q[ITERS-2:0], ge};
            // diff < D < 2^24, so the shift never loses a bit
            r   <= {diff[MAN_W+1:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Sequential float32 divider: Quotient = Number_1 / Number_2, fixed latency.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even (one extra cycle).
module fp_divider
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] Number_1,
    input  logic [31:0] Number_2,
    output logic [31:0] Quotient,
    output logic        Valid,
    output logic        Ready
);

    logic [1:0]       state;
    logic             sgn;
    logic [EXP_W-1:0] e1;
    logic [EXP_W-1:0] e2;
    logic             start;
    logic [ITERS-1:0] q;
    logic             rem_nz;
    logic             done;

    logic signed [9:0] ex;
    logic [MAN_W-1:0]  frac;
    logic [31:0]       res;

    assign Ready = (state == IDLE);
    assign start = Ready && ce;

    fp_div_mant_core u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend ({1'b1, Number_1[MAN_W-1:0]}),
        .divisor  ({1'b1, Number_2[MAN_W-1:0]}),
        .q        (q),
        .rem_nz   (rem_nz),
        .done     (done)
    );

`ifdef FP_DIV_ROUND_NEAREST_EN
    logic [MAN_W:0] mant_r;
    logic           g;
    logic           st;

    always_comb begin
        ex = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(10'(BIAS));
        if (q[ITERS-1]) begin
            frac = q[ITERS-2 -: MAN_W];
            g    = q[1];
            st   = q[0] | rem_nz;
        end else begin
            frac = q[ITERS-3 -: MAN_W];
            g    = q[0];
            st   = rem_nz;
            ex   = ex - 10'sd1;
        end
        mant_r = {1'b0, frac} + {{MAN_W{1'b0}}, g & (st | frac[0])};
        // all-ones mantissa rounds up to 2.0: fraction wraps to 0, exponent bumps
        frac   = mant_r[MAN_W-1:0];
        ex     = ex + $signed({9'b0, mant_r[MAN_W]});
    end
`else
    logic unused_rem;
    assign unused_rem = rem_nz;

    always_comb begin
        ex = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(10'(BIAS));
        if (q[ITERS-1]) begin
            frac = q[ITERS-2 -: MAN_W];
        end else begin
            frac = q[ITERS-3 -: MAN_W];
            ex   = ex - 10'sd1;
        end
    end
`endif

    always_comb begin
        if (e2 == '0)
            res = {sgn, FP_INF};
        else if (e1 == '0)
            res = {sgn, FP_ZERO};
        else if (e1 == '1 || e2 == '1)
            res = {sgn, FP_INF};
        else if (ex <= 10'sd0)
            res = {sgn, FP_ZERO};
        else if (ex >= 10'sd255)
            res = {sgn, FP_INF};
        else
            res = {sgn, ex[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sgn      <= 1'b0;
            e1       <= '0;
            e2       <= '0;
            Quotient <= '0;
            Valid    <= 1'b0;
        end else begin
            Valid <= 1'b0;
            unique case (state)
                IDLE: if (ce) begin
                    sgn   <= Number_1[31] ^ Number_2[31];
                    e1    <= Number_1[30 -: EXP_W];
                    e2    <= Number_2[30 -: EXP_W];
                    state <= DIV;
                end
                DIV: if (done)
                    state <= NORM;
                NORM: begin
                    Quotient <= res;
                    Valid    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: random and directed operands vs an integer-division model.
// Honours FP_DIV_ROUND_NEAREST_EN for the model and the expected latency.
module tb_fp_divider;

`ifdef FP_DIV_ROUND_NEAREST_EN
    localparam int LAT = 27;
`else
    localparam int LAT = 26;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] Number_1 = '0;
    logic [31:0] Number_2 = '0;
    logic [31:0] Quotient;
    logic        Valid;
    logic        Ready;

    fp_divider dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .Number_1 (Number_1),
        .Number_2 (Number_2),
        .Quotient (Quotient),
        .Valid    (Valid),
        .Ready    (Ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int          acc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ncyc = 0;
    bit   ready_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Quotient of the hidden-bit mantissas straight from integer division
    function automatic logic [31:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        logic   s;
        int     e1, e2, ex;
        longint m1, m2, q, mant;
        s  = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        m1 = longint'({1'b1, a[22:0]});
        m2 = longint'({1'b1, b[22:0]});
        if (e2 == 0) return {s, 8'hFF, 23'h0};
        if (e1 == 0) return {s, 31'h0};
        if (e1 == 255 || e2 == 255) return {s, 8'hFF, 23'h0};
        ex = e1 - e2 + 127;
`ifdef FP_DIV_ROUND_NEAREST_EN
        begin
            longint r;
            bit     g, st;
            q = (m1 << 25) / m2;
            r = (m1 << 25) % m2;
            if (q >= (longint'(1) << 25)) begin
                mant = q >> 2;
                g    = q[1];
                st   = q[0] || (r != 0);
            end else begin
                ex   = ex - 1;
                mant = q >> 1;
                g    = q[0];
                st   = (r != 0);
            end
            if (g && (st || mant[0])) mant = mant + 1;
            if (mant >= (longint'(1) << 24)) begin
                mant = mant >> 1;
                ex   = ex + 1;
            end
        end
`else
        q = (m1 << 24) / m2;
        if (q >= (longint'(1) << 24)) begin
            mant = q >> 1;
        end else begin
            ex   = ex - 1;
            mant = q;
        end
`endif
        if (ex <= 0) return {s, 31'h0};
        if (ex >= 255) return {s, 8'hFF, 23'h0};
        return {s, ex[7:0], mant[22:0]};
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            if (Valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_valid: got Valid=1 want no Valid at cycle %0d", ncyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("quot %h/%h", e.a, e.b), Quotient, e.exp);
                    check("latency", 32'(ncyc - e.acc), 32'(LAT));
                    check("ready_low_busy", {31'h0, ready_err}, 32'h0);
                    check("ready_at_valid", {31'h0, Ready}, 32'h1);
                    ready_err = 0;
                end
            end else if (sb.size() > 0 && Ready) begin
                ready_err = 1;
            end
            if (ce && Ready)
                sb.push_back('{model(Number_1, Number_2), ncyc + 1,
                               Number_1, Number_2});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (!Ready && t < 200) begin
            step();
            t++;
        end
        if (!Ready) begin
            n_chk++;
            $display("FAIL ready_timeout: got Ready=0 want 1 within 200 cycles");
        end
        Number_1 = a;
        Number_2 = b;
        ce = 1'b1;
        step();
        ce = 1'b0;
        Number_1 = $urandom;
        Number_2 = $urandom;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else if (sel < 5)  e = (sel == 2) ? 8'($urandom_range(1, 20))
                                          : 8'($urandom_range(230, 254));
        else               e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [31:0] dir_a [9];
    logic [31:0] dir_b [9];

    initial begin
        dir_a = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h3F800000,
                  32'h00000000, 32'h00800000, 32'h7F000000, 32'h3FFFFFFF,
                  32'h7F800000};
        dir_b = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000,
                  32'h40A00000, 32'h7F000000, 32'h3E800000, 32'h3F800001,
                  32'h3F800000};

        #1;
        check("reset_quot", Quotient, 32'h0);
        check("reset_valid", {31'h0, Valid}, 32'h0);
        check("reset_ready", {31'h0, Ready}, 32'h1);
        step();
        step();
        rst = 1'b1;
        step();

        foreach (dir_a[i])
            issue(dir_a[i], dir_b[i]);

        // extra ce mid-operation must be dropped
        issue(32'h40C00000, 32'h40000000);
        repeat (4) step();
        Number_1 = 32'h3F800000;
        Number_2 = 32'h40400000;
        ce = 1'b1;
        step();
        ce = 1'b0;

        // abort in flight
        issue(32'h3F800000, 32'h40400000);
        repeat (9) step();
        #2;
        rst = 1'b0;
        #1;
        check("abort_quot", Quotient, 32'h0);
        check("abort_ready", {31'h0, Ready}, 32'h1);
        check("abort_valid", {31'h0, Valid}, 32'h0);
        sb.delete();
        ready_err = 0;
        step();
        step();
        rst = 1'b1;
        repeat (30) step();

        issue(32'hC1000000, 32'h40000000);

        repeat (60)
            issue(rnd_fp(), rnd_fp());

        begin
            int t = 0;
            while (sb.size() > 0 && t < 200) begin
                step();
                t++;
            end
            if (sb.size() > 0) begin
                n_chk++;
                $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            end
        end
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
